// File: rtl/shift_left_reg8_pkg.sv
// Shared operation encoding for the shift_left_reg8 left-shift register.
// The next-state mux in the top module selects its input from these values.
package shift_left_reg8_pkg;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_SHIFT = 2'd2
   } op_e;

   // Reset is handled separately in the flop, so only en and ldsh are decoded here.
   function automatic op_e decode_op(input logic en, input logic ldsh);
      if (!en)
         return OP_HOLD;
      else if (ldsh)
         return OP_LOAD;
      else
         return OP_SHIFT;
   endfunction

endpackage

// File: rtl/shift_left_reg8.sv
// N-bit left-shift register with synchronous parallel load, clock enable,
// serial input into bit 0, and serial output taken from the MSB.
module shift_left_reg8
   import shift_left_reg8_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         ldsh,
   input  logic         SI,
   input  logic [N-1:0] d,
   output logic         SO,
   output logic [N-1:0] q
);

   op_e          op;
   logic [N-1:0] q_d;
   logic [N-1:0] q_q;

   always_comb begin
      op  = decode_op(en, ldsh);
      q_d = q_q;
      case (op)
         OP_LOAD:  q_d = d;
         OP_SHIFT: q_d = {q_q[N-2:0], SI};
         default:  q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         q_q <= '0;
      else
         q_q <= q_d;
   end

   // SO is taken straight from the state flop, with no extra register stage.
   assign q  = q_q;
   assign SO = q_q[N-1];

endmodule

// File: tb/tb_shift_left_reg8.sv
// Directed and randomized checks of shift_left_reg8 against an arithmetic model.
module tb_shift_left_reg8;

   logic       clk = 1'b0;
   logic       rst, en, ldsh, SI, SO;
   logic [7:0] d, q;
   logic [7:0] m;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] ser_bits;

   shift_left_reg8 #(.N(8)) dut (
      .clk(clk), .rst(rst), .en(en), .ldsh(ldsh), .SI(SI), .d(d), .SO(SO), .q(q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance one edge, update the model and compare.
   task automatic step(input logic r, input logic e, input logic l, input logic s,
                       input logic [7:0] dv, input string tag);
      rst = r; en = e; ldsh = l; SI = s; d = dv;
      @(posedge clk);
      #1;
      if (r)
         m = 8'h00;
      else if (e && l)
         m = dv;
      else if (e)
         m = 8'((int'(m) * 2 + int'(s)) % 256);
      chk({tag, "_q"}, q, m);
      chk({tag, "_so"}, {7'd0, SO}, {7'd0, m / 8'd128});
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; ldsh = 1'b1; SI = 1'b0; d = 8'hA5; m = 8'h00;

      step(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, "rst0");
      chk("rst0_const", q, 8'h00);
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, "rst1");

      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h81, "load81");
      chk("load81_const", q, 8'h81);
      chk("load81_so", {7'd0, SO}, 8'h01);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, "hold");
      chk("hold_const", q, 8'h81);

      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sh1");
      chk("sh1_const", q, 8'h03);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sh2");
      chk("sh2_const", q, 8'h07);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sh3");
      chk("sh3_const", q, 8'h0F);
      chk("sh3_so", {7'd0, SO}, 8'h00);

      // MSB-first serialization of 8'hB4: SO must walk 1,0,1,1,0,1,0,0.
      ser_bits = 8'b1011_0100;
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'hB4, "serload");
      chk("ser_so0", {7'd0, SO}, {7'd0, ser_bits[7]});
      for (int i = 1; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "ser");
         chk($sformatf("ser_so%0d", i), {7'd0, SO}, {7'd0, ser_bits[7-i]});
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "ser8");
      chk("ser_final", q, 8'h00);

      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, "load5a");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'(i % 2 == 0), 8'h00, "gate");
      chk("gate_const", q, 8'h5A);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, "load_si_ign");
      chk("load_si_ign_const", q, 8'h3C);

      // A reset pulse that never meets a rising edge must leave q alone.
      rst = 1'b1; en = 1'b0;
      #2;
      chk("rst_noedge", q, 8'h3C);
      rst = 1'b0;

      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, "midrst");
      chk("midrst_const", q, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "postrst");
      chk("postrst_const", q, 8'h01);

      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(15) == 0), 1'($urandom_range(3) != 0),
              1'($urandom_range(3) == 0), 1'($urandom), 8'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
